host_prog_sequencer: RTL and testbench
======================================

// Module: host_prog_sequencer
// PURPOSE
//  Host-side initiator for the DUT wrapper register map: drives control (reg0), ROM_CTRL (reg2), ROM_DATA (reg3).
//  Loads a program image into pmem word by word, verifies each word via ROM readback (reg6),
//  then releases MIPS reset and single-steps the host clock N times, capturing PC (reg5).
//  Sits between a word-stream source (boot FIFO/UART) and the wrapper's slave-register inputs.
// PARAMETERS
//  ADDR_W       6   pmem word address width (64 words)
//  DATA_W       32  register/data width
//  RD_LAT       2   sysclk cycles from address stable to valid rom_rd (>=1)
//  HALF_PERIOD  4   sysclk cycles per clk_host high and per low phase (>=1)
//  STEP_W       16  step counter width
// PORTS
//  sysclk        in   1       system clock; all logic on rising edge
//  rst           in   1       synchronous, active-high reset
//  start         in   1       1-cycle pulse; begins a run when idle
//  num_words     in   ADDR_W+1 words to load, sampled at start (0 = skip load, >64 clamped to 64)
//  step_count    in   STEP_W  host-clock pulses after reset release, sampled at start
//  wr_valid      in   1       program word available
//  wr_data       in   DATA_W  program word
//  wr_ready      out  1       word accepted when wr_valid & wr_ready
//  busy          out  1       run in progress
//  done          out  1       run completed OK; held until next start
//  error         out  1       readback mismatch; held until next start
//  err_addr      out  ADDR_W  address of first mismatch
//  last_pc       out  DATA_W  reg5 sampled after each falling clk_host edge
//  steps_done    out  STEP_W  completed clk_host pulses
//  to_slv_reg0   out  DATA_W  [0]=rst_host [1]=clk_host [2]=clk_select(1=host clock), rest 0
//  to_slv_reg2   out  DATA_W  [0]=rom_we [6:1]=rom_addr, rest 0
//  to_slv_reg3   out  DATA_W  rom write data
//  from_slv_reg5 in   DATA_W  MIPS PC
//  from_slv_reg6 in   DATA_W  ROM read data
// BEHAVIOUR
//  Reset: reg0=32'h5 (rst_host=1, clk_select=1, clk_host=0); reg2=reg3=0; wr_ready/busy/done/error=0;
//   err_addr=0, last_pc=0, steps_done=0; state IDLE. rst mid-run aborts to these values next cycle.
//  FSM: IDLE -> (start) clear done/error/steps_done, latch counts, busy=1 -> LOAD or RELEASE(num_words=0).
//  LOAD: wr_ready=1; on handshake latch word into reg3, addr into reg2[6:1], rom_we=1 -> WRITE.
//  WRITE: exactly one cycle with rom_we=1; then rom_we=0, wr_ready=0 -> VERIFY.
//  VERIFY: wait RD_LAT cycles, addr/data held; compare reg6 to reg3.
//   mismatch -> ERROR; match & last word -> RELEASE; else addr+1 -> LOAD.
//  rst_host stays 1 throughout LOAD/WRITE/VERIFY; clk_host stays 0.
//  RELEASE: one cycle clearing reg0[0]; -> DONE if step_count=0, else STEP_HI.
//  STEP_HI: clk_host=1 for HALF_PERIOD cycles -> STEP_LO.
//  STEP_LO: clk_host=0 for HALF_PERIOD cycles; last cycle: last_pc<=reg5, steps_done+1;
//   steps_done==step_count -> DONE, else STEP_HI.
//  DONE: busy=0, done=1, rst_host stays 0, clk_host=0. ERROR: busy=0, error=1, rom_we=0, rst_host=1, err_addr=addr.
//  start while busy ignored; start in DONE/ERROR begins new run (rst_host re-asserted first cycle).
//  wr_valid without wr_ready ignored; addr never wraps (load ends at num_words).
//  Phase counter and step counter unsigned; no overflow (step_count <= 2^STEP_W-1).
// TESTING
//  Load 4 words 0x11,0x22,0x33,0x44, ideal ROM model, steps=0 -> 4 single-cycle we pulses addr0..3, done=1, reg0=32'h4.
//  ROM model corrupts addr2 -> error=1, err_addr=2, reg0[0]=1, no clk_host pulses, wr_ready=0.
//  num_words=0, steps=3, PC model +4/edge from 0 -> 3 clk_host pulses 4 cycles high/low, last_pc=12, steps_done=3.
//  wr_valid gapped (low 5 cycles between words) -> no writes during gaps, addr order preserved, done=1.
//  rst asserted during STEP_HI -> next cycle reg0=32'h5, busy=0, steps_done=0; start while busy ignored.
//  num_words=100 -> exactly 64 writes addr 0..63, then RELEASE.

Source files
------------

// File: rtl/host_prog_sequencer_if.sv
// Slave-register bus between the host program sequencer and the DUT wrapper.
// The sequencer drives reg0/reg2/reg3 and reads back PC (reg5) and ROM data (reg6).
interface host_prog_sequencer_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] to_slv_reg0;
  logic [DATA_W-1:0] to_slv_reg2;
  logic [DATA_W-1:0] to_slv_reg3;
  logic [DATA_W-1:0] from_slv_reg5;
  logic [DATA_W-1:0] from_slv_reg6;

  modport master (
    output to_slv_reg0, to_slv_reg2, to_slv_reg3,
    input  from_slv_reg5, from_slv_reg6
  );

  modport slave (
    input  to_slv_reg0, to_slv_reg2, to_slv_reg3,
    output from_slv_reg5, from_slv_reg6
  );
endinterface

// File: rtl/host_prog_sequencer.sv
// Host-side sequencer: loads a program image into pmem with ROM readback verify,
// then releases MIPS reset and single-steps the host clock, capturing the PC.
module host_prog_sequencer #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned STEP_W      = 16
) (
  input  logic                 sysclk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W:0]      num_words,
  input  logic [STEP_W-1:0]    step_count,
  input  logic                 wr_valid,
  input  logic [DATA_W-1:0]    wr_data,
  output logic                 wr_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_W-1:0]    err_addr,
  output logic [DATA_W-1:0]    last_pc,
  output logic [STEP_W-1:0]    steps_done,
  host_prog_sequencer_if.master slv
);

  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned PH_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT - 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(HALF_PERIOD - 1);
  localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_VERIFY,
    S_RELEASE,
    S_STEP_HI,
    S_STEP_LO,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W:0]   nwords;
  logic [ADDR_W:0]   nwords_in;
  logic [STEP_W-1:0] step_tgt;
  logic [ADDR_W-1:0] addr;
  logic [LAT_W-1:0]  lat;
  logic [PH_W-1:0]   phase;
  logic              rst_host;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_wdata;

  logic lat_last;
  logic phase_last;
  logic rd_match;
  logic last_word;
  logic last_step;

  assign nwords_in  = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
  assign lat_last   = (lat == LAT_LAST);
  assign phase_last = (phase == PH_LAST);
  assign rd_match   = (slv.from_slv_reg6 == rom_wdata);
  assign last_word  = (({1'b0, addr} + (ADDR_W+1)'(1)) == nwords);
  assign last_step  = ((steps_done + STEP_W'(1)) == step_tgt);

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wr_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        busy  = 1'b0;
        done  = (state == S_DONE);
        error = (state == S_ERROR);
        if (start) begin
          state_nx = (nwords_in == '0) ? S_RELEASE : S_LOAD;
        end
      end
      S_LOAD: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          state_nx = S_WRITE;
        end
      end
      S_WRITE: state_nx = S_VERIFY;
      S_VERIFY: begin
        if (lat_last) begin
          if (!rd_match) begin
            state_nx = S_ERROR;
          end else if (last_word) begin
            state_nx = S_RELEASE;
          end else begin
            state_nx = S_LOAD;
          end
        end
      end
      S_RELEASE: state_nx = (step_tgt == '0) ? S_DONE : S_STEP_HI;
      S_STEP_HI: begin
        if (phase_last) begin
          state_nx = S_STEP_LO;
        end
      end
      S_STEP_LO: begin
        if (phase_last) begin
          state_nx = last_step ? S_DONE : S_STEP_HI;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Counters restart on every state entry; rst_host is re-asserted on each new run.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      nwords     <= '0;
      step_tgt   <= '0;
      addr       <= '0;
      lat        <= '0;
      phase      <= '0;
      rst_host   <= 1'b1;
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_wdata  <= '0;
      err_addr   <= '0;
      last_pc    <= '0;
      steps_done <= '0;
    end else begin
      lat   <= (state == S_VERIFY && !lat_last) ? lat + LAT_W'(1) : '0;
      phase <= ((state == S_STEP_HI || state == S_STEP_LO) && !phase_last)
               ? phase + PH_W'(1) : '0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            nwords     <= nwords_in;
            step_tgt   <= step_count;
            steps_done <= '0;
            addr       <= '0;
            rst_host   <= 1'b1;
          end
        end
        S_LOAD: begin
          if (wr_valid) begin
            rom_wdata <= wr_data;
            rom_addr  <= addr;
            rom_we    <= 1'b1;
          end
        end
        S_WRITE: rom_we <= 1'b0;
        S_VERIFY: begin
          if (lat_last) begin
            if (!rd_match) begin
              err_addr <= addr;
            end else if (!last_word) begin
              addr <= addr + ADDR_W'(1);
            end
          end
        end
        S_RELEASE: rst_host <= 1'b0;
        S_STEP_LO: begin
          if (phase_last) begin
            last_pc    <= slv.from_slv_reg5;
            steps_done <= steps_done + STEP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // clk_host is high exactly while in STEP_HI; clk_select is tied to the host clock.
  assign slv.to_slv_reg0 = {{(DATA_W-3){1'b0}}, 1'b1, (state == S_STEP_HI), rst_host};
  assign slv.to_slv_reg2 = {{(DATA_W-ADDR_W-1){1'b0}}, rom_addr, rom_we};
  assign slv.to_slv_reg3 = rom_wdata;

endmodule

// File: tb/tb_host_prog_sequencer.sv
// Directed bench for host_prog_sequencer with a ROM readback model and a PC model
// that advances by 4 on every rising clk_host edge.
module tb_host_prog_sequencer;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STEP_W = 16;

  logic              sysclk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   num_words = '0;
  logic [STEP_W-1:0] step_count = '0;
  logic              wr_valid = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] err_addr;
  logic [DATA_W-1:0] last_pc;
  logic [STEP_W-1:0] steps_done;

  host_prog_sequencer_if #(.DATA_W(DATA_W)) bus ();

  host_prog_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .HALF_PERIOD(4), .STEP_W(STEP_W)
  ) dut (
    .sysclk(sysclk), .rst(rst), .start(start), .num_words(num_words),
    .step_count(step_count), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .done(done), .error(error),
    .err_addr(err_addr), .last_pc(last_pc), .steps_done(steps_done),
    .slv(bus)
  );

  always #5 sysclk = ~sysclk;

  // ROM model; corrupt flips bit 8 of the word read back from address 2.
  logic [31:0] rom_mem [0:63];
  logic        corrupt = 1'b0;
  logic [5:0]  rom_a;
  assign rom_a = bus.to_slv_reg2[6:1];
  assign bus.from_slv_reg6 = rom_mem[rom_a] ^ ((corrupt && rom_a == 6'd2) ? 32'h100 : 32'h0);

  logic [31:0] pc = '0;
  logic        clk_prev = 1'b0;
  assign bus.from_slv_reg5 = pc;

  int         we_total = 0, we_cycles = 0, stray = 0, clk_pulses = 0;
  int         run_err = 0, hi_run = 0, lo_run = 0;
  logic       we_prev = 1'b0, hs_prev = 1'b0;
  logic [5:0] wlog [0:255];

  always @(posedge sysclk) begin
    hs_prev  <= wr_valid && wr_ready;
    we_prev  <= bus.to_slv_reg2[0];
    clk_prev <= bus.to_slv_reg0[1];
    if (bus.to_slv_reg2[0]) begin
      we_cycles <= we_cycles + 1;
      rom_mem[rom_a] <= bus.to_slv_reg3;
      if (!hs_prev) stray <= stray + 1;
      if (!we_prev) begin
        wlog[we_total[7:0]] <= rom_a;
        we_total <= we_total + 1;
      end
    end
    if (bus.to_slv_reg0[1]) begin
      hi_run <= hi_run + 1;
      if (!clk_prev) begin
        pc <= pc + 32'd4;
        clk_pulses <= clk_pulses + 1;
        if (lo_run != 0 && lo_run != 4) run_err <= run_err + 1;
        lo_run <= 0;
      end
    end else begin
      if (clk_prev) begin
        if (hi_run != 4) run_err <= run_err + 1;
        hi_run <= 0;
      end
      lo_run <= bus.to_slv_reg0[0] ? 0 : lo_run + 1;
    end
  end

  int n_cmp = 0, n_bad = 0;
  int b_we, b_cyc, b_str, b_clk, b_run, oe, t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W:0] nw, input logic [STEP_W-1:0] sc);
    @(negedge sysclk);
    num_words = nw; step_count = sc; start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input int gap);
    int w = 0;
    wr_data = d; wr_valid = 1'b1;
    while (!wr_ready && w < 100) begin @(negedge sysclk); w++; end
    check("send_ready", wr_ready, 1);
    @(posedge sysclk);
    #1 wr_valid = 1'b0;
    repeat (gap) @(negedge sysclk);
  endtask

  task automatic wait_end(input int maxc, input string tag);
    int w = 0;
    while (!(done || error) && w < maxc) begin @(negedge sysclk); w++; end
    check({tag, "_finished"}, done || error, 1);
  endtask

  task automatic snap();
    b_we = we_total; b_cyc = we_cycles; b_str = stray; b_clk = clk_pulses; b_run = run_err;
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge sysclk);
    check("rst_reg0", bus.to_slv_reg0, 32'h5);
    check("rst_reg2", bus.to_slv_reg2, 32'h0);
    check("rst_reg3", bus.to_slv_reg3, 32'h0);
    check("rst_flags", {wr_ready, busy, done, error}, 4'b0000);
    check("rst_cnts", {err_addr, last_pc, steps_done}, '0);
    rst = 1'b0;
    @(negedge sysclk);

    // T1: load 4 words, ideal ROM, no steps
    snap();
    pulse_start(7'd4, 16'd0);
    send_word(32'h11, 0); send_word(32'h22, 0); send_word(32'h33, 0); send_word(32'h44, 0);
    wait_end(50, "t1");
    check("t1_done_err_busy", {done, error, busy}, 3'b100);
    check("t1_reg0", bus.to_slv_reg0, 32'h4);
    check("t1_we_pulses", we_total - b_we, 4);
    check("t1_we_cycles", we_cycles - b_cyc, 4);
    check("t1_stray", stray - b_str, 0);
    for (int k = 0; k < 4; k++) check("t1_addr_order", wlog[b_we + k], 6'(k));
    check("t1_rom3", rom_mem[3], 32'h44);
    check("t1_clk_pulses", clk_pulses - b_clk, 0);

    // T2: readback corruption at address 2
    corrupt = 1'b1;
    snap();
    pulse_start(7'd4, 16'd5);
    check("t2_rst_host_reassert", bus.to_slv_reg0, 32'h5);
    check("t2_busy", busy, 1);
    send_word(32'h55, 0); send_word(32'h66, 0); send_word(32'h77, 0);
    wait_end(50, "t2");
    check("t2_flags", {done, error, busy, wr_ready}, 4'b0100);
    check("t2_err_addr", err_addr, 6'd2);
    check("t2_reg0", bus.to_slv_reg0, 32'h5);
    check("t2_rom_we", bus.to_slv_reg2[0], 0);
    check("t2_we_pulses", we_total - b_we, 3);
    repeat (5) @(negedge sysclk);
    check("t2_error_held", {error, wr_ready}, 2'b10);
    check("t2_clk_pulses", clk_pulses - b_clk, 0);
    corrupt = 1'b0;

    // T3: no load, three host clock pulses
    snap();
    pulse_start(7'd0, 16'd3);
    wait_end(200, "t3");
    check("t3_done", {done, error}, 2'b10);
    check("t3_last_pc", last_pc, 32'd12);
    check("t3_steps_done", steps_done, 16'd3);
    check("t3_clk_pulses", clk_pulses - b_clk, 3);
    check("t3_half_periods", run_err - b_run, 0);
    check("t3_reg0", bus.to_slv_reg0, 32'h4);
    check("t3_no_writes", we_total - b_we, 0);

    // T4: gapped word stream
    snap();
    pulse_start(7'd3, 16'd0);
    send_word(32'hA1, 5); send_word(32'hB2, 5); send_word(32'hC3, 5);
    wait_end(50, "t4");
    check("t4_done", {done, error}, 2'b10);
    check("t4_we_pulses", we_total - b_we, 3);
    check("t4_stray", stray - b_str, 0);
    for (int k = 0; k < 3; k++) check("t4_addr_order", wlog[b_we + k], 6'(k));
    check("t4_rom2", rom_mem[2], 32'hC3);

    // T5: start while busy ignored, then reset during STEP_HI
    pulse_start(7'd0, 16'd10);
    t = 0;
    while (steps_done < 1 && t < 100) begin @(negedge sysclk); t++; end
    check("t5_first_step", steps_done, 16'd1);
    pulse_start(7'd4, 16'd1);
    check("t5_ignored", {busy, wr_ready, bus.to_slv_reg0[0]}, 3'b100);
    t = 0;
    while (steps_done < 2 && t < 100) begin @(negedge sysclk); t++; end
    t = 0;
    while (!bus.to_slv_reg0[1] && t < 20) begin @(negedge sysclk); t++; end
    check("t5_in_step_hi", {bus.to_slv_reg0[1], steps_done}, {1'b1, 16'd2});
    rst = 1'b1;
    @(posedge sysclk);
    #1;
    check("t5_abort_reg0", bus.to_slv_reg0, 32'h5);
    check("t5_abort_flags", {busy, done, error, wr_ready}, 4'b0000);
    check("t5_abort_steps", steps_done, 16'd0);
    @(negedge sysclk);
    rst = 1'b0;
    @(negedge sysclk);
    check("t5_idle", {busy, done}, 2'b00);

    // T6: num_words above 64 clamps to 64 writes
    snap();
    pulse_start(7'd100, 16'd0);
    for (int k = 0; k < 64; k++) send_word(32'h1000 + k, 0);
    wait_end(50, "t6");
    check("t6_done", {done, error}, 2'b10);
    check("t6_reg0", bus.to_slv_reg0, 32'h4);
    check("t6_we_pulses", we_total - b_we, 64);
    oe = 0;
    for (int k = 0; k < 64; k++) if (wlog[b_we + k] != 6'(k)) oe++;
    check("t6_addr_order", oe, 0);
    check("t6_rom63", rom_mem[63], 32'h103F);
    wr_valid = 1'b1;
    repeat (4) @(negedge sysclk);
    check("t6_no_extra", {wr_ready, 32'(we_total - b_we)}, {1'b0, 32'd64});
    wr_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
